// File: rtl/processor_types_pkg.sv
// Shared processor types: block address offsets plus register-bus arbiter state,
// grant encodings and the default timeout.
package processor_types_pkg;

  typedef enum logic [1:0] {
    B_GLOBAL_OFFSET  = 2'd0,
    B_JPEG_OFFSET    = 2'd1,
    B_SENS_OFFSET    = 2'd2,
    B_DISPLAY_OFFSET = 2'd3
  } addr_offset_t;

  typedef enum logic [1:0] {
    S_ARB_IDLE,
    S_ARB_ACCESS,
    S_ARB_RESP
  } reg_arb_state_t;

  typedef enum logic {
    GRANT_M0,
    GRANT_M1
  } arb_grant_t;

  localparam int REG_BUS_TIMEOUT_DFLT = 15;

  function automatic logic [3:0] blk_onehot(input addr_offset_t off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Register bus bundle: two requester ports on one side, four block spaces on the other.
// The arbiter uses the master modport (it masters the block bus); the environment uses slave.
interface reg_bus_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 8
);
  logic                  m0_req, m1_req;
  logic                  m0_we, m1_we;
  logic [REG_AW+1:0]     m0_addr, m1_addr;
  logic [DATA_W-1:0]     m0_wdata, m1_wdata;
  logic                  m0_ack, m1_ack;
  logic                  m0_err, m1_err;
  logic [DATA_W-1:0]     m_rdata;
  logic [3:0]            s_sel;
  logic                  s_we;
  logic [REG_AW-1:0]     s_addr;
  logic [DATA_W-1:0]     s_wdata;
  logic [3:0]            s_ack;
  logic [4*DATA_W-1:0]   s_rdata;

  modport master (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  s_ack, s_rdata,
    output m0_ack, m1_ack, m0_err, m1_err, m_rdata,
    output s_sel, s_we, s_addr, s_wdata
  );

  modport slave (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output s_ack, s_rdata,
    input  m0_ack, m1_ack, m0_err, m1_err, m_rdata,
    input  s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin pick: a tie goes to the requester not granted last.
module reg_bus_rr_pick
  import processor_types_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_grant_t last,
  output arb_grant_t grant,
  output logic       valid
);
  always_comb begin
    valid = req0 | req1;
    grant = GRANT_M0;
    if (req0 && req1) grant = (last == GRANT_M0) ? GRANT_M1 : GRANT_M0;
    else if (req1)    grant = GRANT_M1;
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-requester register bus arbiter with block decode and one ack per transaction.
// Optional access timeout enabled by defining REG_BUS_TIMEOUT_EN.
module reg_bus_arbiter
  import processor_types_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REG_AW      = 8,
  parameter int TIMEOUT_CYC = REG_BUS_TIMEOUT_DFLT
) (
  input logic              clk,
  input logic              rst,
  reg_bus_arbiter_if.master bus
);
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  reg_arb_state_t    state_q, state_d;
  arb_grant_t        last_q, gnt_q, pick_gnt;
  logic              pick_vld;
  addr_offset_t      blk_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [REG_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              sel_ack, timeout, rsp_err;
  logic              win_we;
  logic [REG_AW+1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  reg_bus_rr_pick u_pick (
    .req0  (bus.m0_req),
    .req1  (bus.m1_req),
    .last  (last_q),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  // sel_q is one-hot while in ACCESS, so acks from other blocks are masked out
  assign sel_ack = |(bus.s_ack & sel_q);

  always_comb begin
    win_we    = bus.m0_we;
    win_addr  = bus.m0_addr;
    win_wdata = bus.m0_wdata;
    if (pick_gnt == GRANT_M1) begin
      win_we    = bus.m1_we;
      win_addr  = bus.m1_addr;
      win_wdata = bus.m1_wdata;
    end
  end

`ifdef REG_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst)                          tcnt_q <= '0;
    else if (state_q == S_ARB_IDLE)   tcnt_q <= '0;
    else if (state_q == S_ARB_ACCESS) tcnt_q <= tcnt_q + 1'b1;
  end

  // tcnt_q counts completed ACCESS cycles, so TIMEOUT_CYC-1 marks the last allowed one
  assign timeout = (state_q == S_ARB_ACCESS) && (tcnt_q == CW'(TIMEOUT_CYC - 1)) && !sel_ack;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == S_ARB_ACCESS && (sel_ack || timeout)) err_q <= !sel_ack;
  end
  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARB_IDLE:   if (pick_vld) state_d = S_ARB_ACCESS;
      S_ARB_ACCESS: if (sel_ack || timeout) state_d = S_ARB_RESP;
      S_ARB_RESP:   state_d = S_ARB_IDLE;
      default:      state_d = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= GRANT_M1;
      gnt_q   <= GRANT_M0;
      blk_q   <= B_GLOBAL_OFFSET;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_ARB_IDLE: if (pick_vld) begin
          gnt_q   <= pick_gnt;
          last_q  <= pick_gnt;
          blk_q   <= addr_offset_t'(win_addr[REG_AW+1:REG_AW]);
          sel_q   <= blk_onehot(addr_offset_t'(win_addr[REG_AW+1:REG_AW]));
          we_q    <= win_we;
          addr_q  <= win_addr[REG_AW-1:0];
          wdata_q <= win_wdata;
        end
        S_ARB_ACCESS: begin
          if (sel_ack) begin
            rdata_q <= we_q ? '0 : bus.s_rdata[int'(blk_q)*DATA_W +: DATA_W];
            sel_q   <= '0;
          end else if (timeout) begin
            rdata_q <= '1;
            sel_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_sel   = sel_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.m_rdata = rdata_q;
  assign bus.m0_ack  = (state_q == S_ARB_RESP) && (gnt_q == GRANT_M0);
  assign bus.m1_ack  = (state_q == S_ARB_RESP) && (gnt_q == GRANT_M1);
  assign bus.m0_err  = bus.m0_ack && rsp_err;
  assign bus.m1_err  = bus.m1_ack && rsp_err;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed cases plus randomized traffic against a
// transaction-level model (round-robin winner, 2+delay latency, decoded block).
module tb_reg_bus_arbiter;
  import processor_types_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bus_arbiter_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  reg_bus_arbiter #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_w = 1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic we, input logic [9:0] addr, input logic [7:0] wd);
    if (m == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
    end
  endtask

  // Called on the negedge of an IDLE cycle with requests already set.
  task automatic txn(input int dly, input logic [7:0] rd, input bit stray,
                     output int acyc, output int wo);
    int w, blk, lat;
    logic [9:0] a;
    logic we;
    logic [7:0] wd, erd;
    bit to;
    if (bus.m0_req && bus.m1_req) w = 1 - last_w;
    else                          w = bus.m1_req ? 1 : 0;
    last_w = w;
    wo = w;
    a   = w ? bus.m1_addr  : bus.m0_addr;
    we  = w ? bus.m1_we    : bus.m0_we;
    wd  = w ? bus.m1_wdata : bus.m0_wdata;
    blk = int'(a[9:8]);
    lat = dly;
    to  = 1'b0;
`ifdef REG_BUS_TIMEOUT_EN
    if (dly >= TMO) begin lat = TMO - 1; to = 1'b1; end
`endif
    erd = to ? 8'hFF : (we ? 8'h00 : rd);
    @(negedge clk);
    chk("s_we",    32'(bus.s_we),    32'(we));
    chk("s_wdata", 32'(bus.s_wdata), 32'(wd));
    for (int k = 0; k <= lat; k++) begin
      chk("sel",        32'(bus.s_sel),  32'(1 << blk));
      chk("s_addr",     32'(bus.s_addr), 32'(a[7:0]));
      chk("early_ack",  32'({bus.m0_ack, bus.m1_ack}), 32'(0));
      bus.s_rdata = 32'($urandom);
      bus.s_ack   = stray ? ~(4'b0001 << blk) : 4'b0000;
      if (k == dly) begin
        bus.s_ack = 4'b0001 << blk;
        bus.s_rdata[blk*8 +: 8] = rd;
      end
      @(negedge clk);
    end
    bus.s_ack = 4'b0000;
    acyc = cyc;
    chk("ack_win",  32'(w ? bus.m1_ack : bus.m0_ack), 32'(1));
    chk("ack_lose", 32'(w ? bus.m0_ack : bus.m1_ack), 32'(0));
    chk("err",      32'(w ? bus.m1_err : bus.m0_err), 32'(to));
    chk("rdata",    32'(bus.m_rdata), 32'(erd));
    chk("sel_drop", 32'(bus.s_sel),   32'(0));
    if (w == 1) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
    @(negedge clk);
    chk("ack_pulse",  32'({bus.m0_ack, bus.m1_ack}), 32'(0));
    chk("rdata_hold", 32'(bus.m_rdata), 32'(erd));
  endtask

  initial begin
    int ac, prev, wo;
    rst = 1'b1;
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
    bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_wdata = '0; bus.m1_wdata = '0;
    bus.s_ack = '0; bus.s_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel",   32'(bus.s_sel), 32'(0));
    chk("rst_out",   32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.s_we}), 32'(0));
    chk("rst_addr",  32'(bus.s_addr), 32'(0));
    chk("rst_wdata", 32'(bus.s_wdata), 32'(0));
    chk("rst_rdata", 32'(bus.m_rdata), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // m0 write to jpeg, immediate ack
    set_m(0, 1'b1, {B_JPEG_OFFSET, 8'h05}, 8'h3C);
    txn(0, 8'h77, 1'b0, ac, wo);

    // m1 read of display, three cycles late
    set_m(1, 1'b0, {B_DISPLAY_OFFSET, 8'h10}, 8'h00);
    prev = cyc;
    txn(3, 8'hA5, 1'b0, ac, wo);
    chk("lat_m1", 32'(ac - prev), 32'(5));

    // both requesters keep requesting the global block
    set_m(0, 1'b0, {B_GLOBAL_OFFSET, 8'h01}, 8'h11);
    set_m(1, 1'b1, {B_GLOBAL_OFFSET, 8'h02}, 8'h22);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      txn(0, 8'(8'h40 + i), 1'b0, ac, wo);
      chk("tie_order", 32'(wo), 32'(i % 2));
      if (i > 0) chk("tie_spacing", 32'(ac - prev), 32'(3));
      prev = ac;
      if (i < 3) begin
        if (wo == 0) set_m(0, 1'b0, {B_GLOBAL_OFFSET, 8'h01}, 8'h11);
        else         set_m(1, 1'b1, {B_GLOBAL_OFFSET, 8'h02}, 8'h22);
      end
    end
    bus.m0_req = 0; bus.m1_req = 0;

    // stray acks from other blocks while sens is selected
    set_m(0, 1'b0, {B_SENS_OFFSET, 8'h33}, 8'h00);
    txn(2, 8'hC3, 1'b1, ac, wo);

    // reset in the middle of an m0 access to sens
    set_m(0, 1'b0, {B_SENS_OFFSET, 8'h22}, 8'h00);
    @(negedge clk);
    chk("mid_sel", 32'(bus.s_sel), 32'(4'b0100));
    rst = 1'b1;
    bus.m0_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_sel",   32'(bus.s_sel), 32'(0));
    chk("mid_rst_out",   32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.s_we}), 32'(0));
    chk("mid_rst_bus",   32'({bus.s_addr, bus.s_wdata}), 32'(0));
    chk("mid_rst_rdata", 32'(bus.m_rdata), 32'(0));
    rst = 1'b0;
    last_w = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ack_after_rst", 32'({bus.m0_ack, bus.m1_ack}), 32'(0));
    end
    set_m(0, 1'b0, {B_GLOBAL_OFFSET, 8'h09}, 8'h00);
    set_m(1, 1'b0, {B_JPEG_OFFSET, 8'h0A}, 8'h00);
    txn(1, 8'h5D, 1'b0, ac, wo);
    chk("first_tie_m0", 32'(wo), 32'(0));
    txn(0, 8'h6E, 1'b0, ac, wo);

`ifdef REG_BUS_TIMEOUT_EN
    set_m(0, 1'b0, {B_SENS_OFFSET, 8'h44}, 8'h00);
    prev = cyc;
    txn(1000, 8'h00, 1'b0, ac, wo);
    chk("tmo_lat", 32'(ac - prev), 32'(1 + TMO));
    set_m(0, 1'b0, {B_SENS_OFFSET, 8'h45}, 8'h00);
    prev = cyc;
    txn(TMO - 1, 8'h5A, 1'b0, ac, wo);
    chk("tmo_edge_lat", 32'(ac - prev), 32'(1 + TMO));
`endif

    // randomized traffic; a pending loser keeps its request and fields
    for (int i = 0; i < 30; i++) begin
      if (!bus.m0_req && $urandom_range(0, 1) == 1)
        set_m(0, 1'($urandom), 10'($urandom), 8'($urandom));
      if (!bus.m1_req && $urandom_range(0, 1) == 1)
        set_m(1, 1'($urandom), 10'($urandom), 8'($urandom));
      if (!bus.m0_req && !bus.m1_req)
        set_m(int'($urandom_range(0, 1)), 1'($urandom), 10'($urandom), 8'($urandom));
      prev = cyc;
      txn(int'($urandom_range(0, 4)), 8'($urandom), 1'($urandom_range(0, 1)), ac, wo);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Shares one register bus between two requesters and decodes each access onto one of four block register spaces. Requester 0 is the processor's memory stage; requester 1 is the real-time measurement engine. Each access is routed by the 2-bit block offset `addr_offset_t` (global/jpeg/sens/display) to a one-hot block select. Arbitration is round-robin, and the block completes every transaction with exactly one ack pulse, optionally guarded by a timeout.

## Interface
Parameters:
- `DATA_W`, 8: register data width.
- `REG_AW`, 8: in-block register address width. Requester address width is `REG_AW+2`; the top 2 bits are the block offset.
- `TIMEOUT_CYC`, 15: number of ACCESS cycles without a slave ack before an error response (timeout build only).

Ports:
- `clk`  in  1: sole clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1: access request. Address, write enable and write data stay stable while high.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  REG_AW+2: `{addr_offset_t, reg_addr}`.
- `m0_wdata`, `m1_wdata`  in  DATA_W: write data.
- `m0_ack`, `m1_ack`  out  1: one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1: valid with ack; 1 = timed out.
- `m_rdata`  out  DATA_W: read data, valid with either ack.
- `s_sel`  out  4: one-hot block select, index = block offset.
- `s_we`  out  1: write enable to the block.
- `s_addr`  out  REG_AW: in-block register address.
- `s_wdata`  out  DATA_W: write data to the block.
- `s_ack`  in  4: per-block ack, one bit per block.
- `s_rdata`  in  4*DATA_W: packed read data; block i occupies bits `[i*DATA_W +: DATA_W]`.

## Operation
- Three-state FSM:
  - S_IDLE: no transaction active.
  - S_ACCESS: block selected, waiting for its ack.
  - S_RESP: requester ack cycle.
- S_IDLE, with any request high:
  - Pick a winner and latch its we/addr/wdata.
  - Register `s_sel = 1 << addr[REG_AW+1:REG_AW]`, plus `s_we`, `s_addr`, `s_wdata`.
  - Go to S_ACCESS.
- Arbitration:
  - If only one request is high, that requester wins.
  - If both are high, the requester not granted last time wins.
  - Reset leaves the pointer so that m0 wins the first tie.
- S_ACCESS:
  - Only `s_ack[sel]` counts; acks from unselected blocks are ignored.
  - On the selected ack: capture `s_rdata` slice (reads) or 0 (writes) into `m_rdata`, drop `s_sel`, go to S_RESP.
- S_RESP:
  - The winner's `mX_ack` is 1 for this cycle only.
  - Then return to S_IDLE.
- A requester must drop req at the end of its ack cycle. A req still high in the following S_IDLE is treated as a new transaction.
- Reset in any state:
  - Next state is S_IDLE; pending transaction is discarded and no ack is issued.
  - All outputs go to 0.

## Timing
- Reset values: `s_sel=0`, `s_we=0`, `s_addr=0`, `s_wdata=0`, both acks 0, both errs 0, `m_rdata=0`, round-robin pointer = "m1 last".
- Transaction timeline:
  - req sampled in S_IDLE at cycle N.
  - `s_sel` valid at N+1.
  - Earliest slave ack at N+1.
  - `mX_ack` at N+2.
- Minimum req-to-ack latency is 2 cycles; minimum transaction spacing is 3 cycles.
- Each extra cycle without a slave ack adds one cycle of latency.
- `s_we`/`s_addr`/`s_wdata` are stable for the whole S_ACCESS dwell.
- `m_rdata` and `mX_err` are valid only in the ack cycle. `m_rdata` holds its value otherwise.

## Configuration
- `REG_BUS_TIMEOUT_EN` defined:
  - A counter cleared on S_IDLE→S_ACCESS counts ACCESS cycles.
  - When it reaches `TIMEOUT_CYC` with no selected ack: drop `s_sel`, set `m_rdata = {DATA_W{1'b1}}`, go to S_RESP with `mX_err=1`.
  - If an ack arrives on the timeout cycle, the ack wins (`err=0`).
- `REG_BUS_TIMEOUT_EN` undefined:
  - No counter; S_ACCESS waits indefinitely.
  - `m0_err`/`m1_err` tied to 0.

## Structure
- Add to `processor_types_pkg`:
  - `reg_arb_state_t {S_ARB_IDLE, S_ARB_ACCESS, S_ARB_RESP}`.
  - `arb_grant_t {GRANT_M0, GRANT_M1}`.
  - Default timeout constant `REG_BUS_TIMEOUT_DFLT = 15`.
- Decode uses the existing `addr_offset_t`.
- One sub-module: `reg_bus_rr_pick`.
  - Combinational 2-way round-robin selector over (`req0`, `req1`, `last`), outputs grant and valid.
  - The pointer register stays in the arbiter.

## Test plan
- Reset: assert `rst` mid-ACCESS with `s_sel=4'b0100` → next cycle all outputs 0, S_IDLE, no ack; after release, first tie goes to m0.
- m0 write to `{B_JPEG_OFFSET, 8'h05}` with data `8'h3C`, jpeg acks at N+1 → `s_sel=4'b0010`, `s_addr=8'h05`, `s_wdata=8'h3C` at N+1; `m0_ack=1`, `m0_err=0` at N+2; `m1_ack=0`.
- m1 read of `{B_DISPLAY_OFFSET, 8'h10}`, display acks 3 cycles late with `8'hA5` → `m1_ack` at N+5 with `m_rdata=8'hA5`.
- Both requesters hold req for 4 transactions to the global block, 1-cycle ack each → grants m0, m1, m0, m1, one ack every 3 cycles.
- Stray `s_ack=4'b0001` while sens is selected → ignored; transaction completes only on `s_ack[2]`.
- `REG_BUS_TIMEOUT_EN` build, sens never acks, m0 read → `m0_ack=1`, `m0_err=1`, `m_rdata=8'hFF` at N+1+15; a second run with the ack on cycle 15 → `err=0`.
